// File: rtl/circle_layer_renderer.sv
// circle_layer_renderer: 3-stage multi-slot circle coverage test per pixel, double-buffered slot config.
// Define CIRCLE_RING_EN for ring mode ((r-t)^2 <= d^2 < r^2); default build draws filled discs.
module circle_layer_renderer #(
    parameter int N_CIRCLES = 4,
    parameter int SCREEN_W  = 96,
    parameter int SCREEN_H  = 64,
    parameter int COORD_W   = 8,
    parameter int RADIUS_W  = 7,
    parameter int COLOR_W   = 16,
    localparam int SEL_W    = (N_CIRCLES > 1) ? $clog2(N_CIRCLES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [12:0]         pixel_index,
    input  logic                pixel_valid,
    input  logic                frame_start,
    input  logic                cfg_we,
    output logic                cfg_ready,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic                cfg_en,
    input  logic [COORD_W-1:0]  cfg_x,
    input  logic [COORD_W-1:0]  cfg_y,
    input  logic [RADIUS_W-1:0] cfg_r,
    input  logic [RADIUS_W-1:0] cfg_t,
    input  logic [COLOR_W-1:0]  cfg_color,
    output logic                out_valid,
    output logic                draw,
    output logic [COLOR_W-1:0]  color_out,
    output logic [SEL_W-1:0]    hit_id
);
    localparam int DW   = COORD_W + 1;
    localparam int D2_W = 2 * DW + 1;
    localparam int R2_W = 2 * RADIUS_W;
    localparam int MW   = (D2_W > R2_W) ? D2_W : R2_W;

    typedef struct packed {
        logic                en;
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [RADIUS_W-1:0] r;
`ifdef CIRCLE_RING_EN
        logic [RADIUS_W-1:0] t;
`endif
        logic [COLOR_W-1:0]  color;
    } slot_t;

    slot_t sh_q [N_CIRCLES];
    slot_t act_q [N_CIRCLES];
    slot_t wr;
    logic  cfg_acc;

    assign cfg_ready = !frame_start && !reset;
    assign cfg_acc   = cfg_we && cfg_ready && int'(cfg_sel) < N_CIRCLES;

    always_comb begin
        wr.en    = cfg_en;
        wr.x     = cfg_x;
        wr.y     = cfg_y;
        wr.r     = cfg_r;
`ifdef CIRCLE_RING_EN
        wr.t     = cfg_t;
`endif
        wr.color = cfg_color;
    end

`ifndef CIRCLE_RING_EN
    logic unused_t;
    assign unused_t = ^cfg_t;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CIRCLES; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            if (cfg_acc) sh_q[cfg_sel] <= wr;
            if (frame_start) act_q <= sh_q;
        end
    end

    logic               v1_q, in1_q;
    logic [COORD_W-1:0] x1_q, y1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            in1_q <= 1'b0;
            x1_q  <= '0;
            y1_q  <= '0;
        end else begin
            v1_q  <= pixel_valid;
            in1_q <= int'(pixel_index) < SCREEN_W * SCREEN_H;
            x1_q  <= COORD_W'(int'(pixel_index) % SCREEN_W);
            y1_q  <= COORD_W'(int'(pixel_index) / SCREEN_W);
        end
    end

    logic signed [DW-1:0]   dx [N_CIRCLES];
    logic signed [DW-1:0]   dy [N_CIRCLES];
    logic signed [2*DW-1:0] sx [N_CIRCLES];
    logic signed [2*DW-1:0] sy [N_CIRCLES];
    logic [D2_W-1:0]        d2_d [N_CIRCLES];
    logic [D2_W-1:0]        d2_q [N_CIRCLES];
    logic [R2_W-1:0]        r2_d [N_CIRCLES];
    logic [R2_W-1:0]        r2_q [N_CIRCLES];
    logic                   en2_d [N_CIRCLES];
    logic                   en2_q [N_CIRCLES];
    logic [COLOR_W-1:0]     col2_q [N_CIRCLES];
    logic                   v2_q;
`ifdef CIRCLE_RING_EN
    logic [RADIUS_W-1:0]    te [N_CIRCLES];
    logic [R2_W-1:0]        i2_d [N_CIRCLES];
    logic [R2_W-1:0]        i2_q [N_CIRCLES];
`endif

    // Squares are taken at full signed width so off-screen centres never wrap.
    always_comb begin
        for (int i = 0; i < N_CIRCLES; i++) begin
            dx[i]   = $signed({1'b0, x1_q}) - $signed({1'b0, act_q[i].x});
            dy[i]   = $signed({1'b0, y1_q}) - $signed({1'b0, act_q[i].y});
            sx[i]   = dx[i] * dx[i];
            sy[i]   = dy[i] * dy[i];
            d2_d[i] = D2_W'($unsigned(sx[i])) + D2_W'($unsigned(sy[i]));
            r2_d[i] = R2_W'(act_q[i].r) * R2_W'(act_q[i].r);
`ifdef CIRCLE_RING_EN
            te[i]    = (act_q[i].t > act_q[i].r) ? act_q[i].r : act_q[i].t;
            i2_d[i]  = R2_W'(act_q[i].r - te[i]) * R2_W'(act_q[i].r - te[i]);
            en2_d[i] = act_q[i].en && in1_q && act_q[i].t != '0;
`else
            en2_d[i] = act_q[i].en && in1_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q <= 1'b0;
            for (int i = 0; i < N_CIRCLES; i++) begin
                d2_q[i]   <= '0;
                r2_q[i]   <= '0;
                en2_q[i]  <= 1'b0;
                col2_q[i] <= '0;
`ifdef CIRCLE_RING_EN
                i2_q[i]   <= '0;
`endif
            end
        end else begin
            v2_q <= v1_q;
            for (int i = 0; i < N_CIRCLES; i++) begin
                d2_q[i]   <= d2_d[i];
                r2_q[i]   <= r2_d[i];
                en2_q[i]  <= en2_d[i];
                col2_q[i] <= act_q[i].color;
`ifdef CIRCLE_RING_EN
                i2_q[i]   <= i2_d[i];
`endif
            end
        end
    end

    logic               h, draw_d;
    logic [COLOR_W-1:0] color_d;
    logic [SEL_W-1:0]   id_d;

    // Scan from the top slot down so the lowest hitting index is written last.
    always_comb begin
        h       = 1'b0;
        draw_d  = 1'b0;
        color_d = '0;
        id_d    = '0;
        for (int i = N_CIRCLES - 1; i >= 0; i--) begin
            h = v2_q && en2_q[i] && MW'(d2_q[i]) < MW'(r2_q[i]);
`ifdef CIRCLE_RING_EN
            h = h && MW'(d2_q[i]) >= MW'(i2_q[i]);
`endif
            if (h) begin
                draw_d  = 1'b1;
                color_d = col2_q[i];
                id_d    = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            draw      <= 1'b0;
            color_out <= '0;
            hit_id    <= '0;
        end else begin
            out_valid <= v2_q;
            draw      <= draw_d;
            color_out <= color_d;
            hit_id    <= id_d;
        end
    end
endmodule

// File: tb/tb_circle_layer_renderer.sv
// tb_circle_layer_renderer: table vectors, hand sequences and random traffic checked against an arithmetic model.
module tb_circle_layer_renderer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset, pixel_valid, frame_start, cfg_we, cfg_ready, cfg_en;
    logic        out_valid, draw;
    logic [12:0] pixel_index;
    logic [1:0]  cfg_sel, hit_id;
    logic [7:0]  cfg_x, cfg_y;
    logic [6:0]  cfg_r, cfg_t;
    logic [15:0] cfg_color, color_out;

    always #5 clk = ~clk;

    circle_layer_renderer dut (
        .clk(clk), .reset(reset), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_r(cfg_r), .cfg_t(cfg_t),
        .cfg_color(cfg_color), .out_valid(out_valid), .draw(draw), .color_out(color_out),
        .hit_id(hit_id)
    );

    typedef struct {logic en; int x; int y; int r; int t; logic [15:0] c;} slot_m_t;
    typedef struct {logic v; logic d; logic [15:0] c; logic [1:0] id;} exp_t;
    typedef struct {int ph; int idx; logic d; logic [15:0] c; logic [1:0] id;} vec_t;

    slot_m_t sh [N];
    slot_m_t act [N];
    exp_t    q [$];
    vec_t    tab [$];
    int      tests = 0, fails = 0, draw_cnt = 0;

    function automatic int pix(int x, int y);
        return y * 96 + x;
    endfunction

    function automatic exp_t model(logic v, int idx);
        exp_t e;
        int px, py;
        e = '{v, 1'b0, 16'h0, 2'd0};
        px = idx % 96;
        py = idx / 96;
        if (idx >= 96 * 64) return e;
        for (int s = 0; s < N; s++) begin
            int d2, rr, ti;
            bit hit;
            d2  = (px - act[s].x) * (px - act[s].x) + (py - act[s].y) * (py - act[s].y);
            rr  = act[s].r * act[s].r;
            hit = act[s].en && d2 < rr;
`ifdef CIRCLE_RING_EN
            ti  = (act[s].t < act[s].r) ? act[s].t : act[s].r;
            hit = hit && act[s].t != 0 && d2 >= (act[s].r - ti) * (act[s].r - ti);
`else
            ti  = 0;
`endif
            if (hit) begin
                e.d  = 1'b1;
                e.c  = act[s].c;
                e.id = 2'(s);
                return e;
            end
        end
        return e;
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    task automatic advance(input exp_t e);
        exp_t x;
        if (reset) begin
            for (int s = 0; s < N; s++) begin
                sh[s]  = '{1'b0, 0, 0, 0, 0, 16'h0};
                act[s] = '{1'b0, 0, 0, 0, 0, 16'h0};
            end
            q.delete();
        end else begin
            if (cfg_we && !frame_start && int'(cfg_sel) < N)
                sh[cfg_sel] = '{cfg_en, int'(cfg_x), int'(cfg_y), int'(cfg_r), int'(cfg_t), cfg_color};
            if (frame_start) act = sh;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reset) chk("reset_outputs", {13'h0, out_valid, draw, hit_id, color_out}, 32'h0);
        else if (q.size() == 3) begin
            x = q.pop_front();
            chk("out_valid", {31'h0, out_valid}, {31'h0, x.v});
            if (x.v) chk("pixel", {13'h0, draw, color_out, hit_id}, {13'h0, x.d, x.c, x.id});
        end else chk("out_valid_idle", {31'h0, out_valid}, 32'h0);
        if (out_valid && draw) draw_cnt++;
    endtask

    task automatic tick();
        advance(model(pixel_valid, int'(pixel_index)));
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic write(input int sel, input int en, input int x, input int y, input int r,
                         input int t, input logic [15:0] c);
        cfg_sel = 2'(sel); cfg_en = en[0]; cfg_x = 8'(x); cfg_y = 8'(y);
        cfg_r = 7'(r); cfg_t = 7'(t); cfg_color = c; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic stream_frame();
        int i;
        i = 0;
        while (i < 6144) begin
            pixel_valid = ($urandom_range(0, 7) != 0);
            pixel_index = 13'(i);
            tick();
            if (pixel_valid) i++;
        end
        idle(3);
    endtask

    task automatic run_tab(input int p);
        foreach (tab[i]) if (tab[i].ph == p) begin
            pixel_valid = 1'b1;
            pixel_index = 13'(tab[i].idx);
            advance('{1'b1, tab[i].d, tab[i].c, tab[i].id});
        end
        idle(3);
    endtask

    initial begin
        tab.push_back('{0, pix(48, 32), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{0, pix(53, 32), 1'b0, 16'h0, 2'd0});
        tab.push_back('{0, pix(43, 32), 1'b0, 16'h0, 2'd0});
        tab.push_back('{0, pix(51, 32), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{0, pix(48, 28), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{0, pix(48, 27), 1'b0, 16'h0, 2'd0});
        tab.push_back('{0, pix(52, 35), 1'b0, 16'h0, 2'd0});
        tab.push_back('{0, pix(51, 35), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{0, 6200, 1'b0, 16'h0, 2'd0});
        tab.push_back('{1, pix(10, 10), 1'b1, 16'h07E0, 2'd0});
        tab.push_back('{1, pix(13, 10), 1'b1, 16'h07E0, 2'd0});
        tab.push_back('{1, pix(7, 10), 1'b1, 16'h07E0, 2'd0});
        tab.push_back('{1, pix(14, 10), 1'b0, 16'h0, 2'd0});
        tab.push_back('{1, pix(0, 0), 1'b1, 16'hFFE0, 2'd2});
        tab.push_back('{1, pix(6, 6), 1'b1, 16'hFFE0, 2'd2});
        tab.push_back('{1, pix(95, 63), 1'b0, 16'h0, 2'd0});
        tab.push_back('{1, pix(90, 60), 1'b0, 16'h0, 2'd0});
        tab.push_back('{3, pix(48, 32), 1'b0, 16'h0, 2'd0});
        tab.push_back('{4, pix(48, 32), 1'b1, 16'h1234, 2'd2});
        tab.push_back('{4, pix(60, 20), 1'b0, 16'h0, 2'd0});
        tab.push_back('{5, pix(60, 20), 1'b1, 16'hABCD, 2'd3});
        tab.push_back('{5, pix(48, 32), 1'b1, 16'h1234, 2'd2});
        tab.push_back('{5, pix(55, 26), 1'b1, 16'h1234, 2'd2});
        tab.push_back('{6, pix(48, 32), 1'b0, 16'h0, 2'd0});
        tab.push_back('{6, pix(10, 10), 1'b0, 16'h0, 2'd0});
`ifdef CIRCLE_RING_EN
        tab.push_back('{2, pix(48, 32), 1'b0, 16'h0, 2'd0});
        tab.push_back('{2, pix(51, 32), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{2, pix(52, 32), 1'b1, 16'hF800, 2'd0});
        tab.push_back('{2, pix(53, 32), 1'b0, 16'h0, 2'd0});
`endif

        reset = 1'b1; pixel_valid = 1'b0; pixel_index = '0; frame_start = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
        cfg_r = '0; cfg_t = '0; cfg_color = '0;
        #1 chk("cfg_ready_in_reset", {31'h0, cfg_ready}, 32'h0);
        repeat (2) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        reset = 1'b0;
        #1 chk("cfg_ready_idle", {31'h0, cfg_ready}, 32'h1);

        draw_cnt = 0;
        stream_frame();
        chk("empty_frame_draws", draw_cnt, 0);

        write(0, 1, 48, 32, 5, 127, 16'hF800);
        commit();
        draw_cnt = 0;
        stream_frame();
        chk("disc_r5_pixel_count", draw_cnt, 69);
        run_tab(0);

`ifdef CIRCLE_RING_EN
        write(0, 1, 48, 32, 5, 2, 16'hF800);
        commit();
        run_tab(2);
`endif

        write(0, 1, 10, 10, 4, 127, 16'h07E0);
        write(1, 1, 10, 10, 4, 127, 16'h001F);
        write(2, 1, 2, 2, 6, 127, 16'hFFE0);
        write(3, 1, 90, 60, 0, 127, 16'hFFFF);
        commit();
        run_tab(1);
        stream_frame();

        for (int i = 0; i < 200; i++) begin
            pixel_valid = 1'b1;
            pixel_index = 13'($urandom_range(0, 6143));
            cfg_we = (i == 100);
            cfg_sel = 2'd2; cfg_en = 1'b1; cfg_x = 8'd48; cfg_y = 8'd32;
            cfg_r = 7'd10; cfg_t = 7'd127; cfg_color = 16'h1234;
            tick();
        end
        cfg_we = 1'b0;
        idle(3);
        run_tab(3);

        cfg_sel = 2'd3; cfg_en = 1'b1; cfg_x = 8'd60; cfg_y = 8'd20;
        cfg_r = 7'd8; cfg_t = 7'd127; cfg_color = 16'hABCD;
        cfg_we = 1'b1; frame_start = 1'b1;
        #1 chk("cfg_ready_frame_start", {31'h0, cfg_ready}, 32'h0);
        tick();
        frame_start = 1'b0;
        #1 chk("cfg_ready_after_commit", {31'h0, cfg_ready}, 32'h1);
        tick();
        cfg_we = 1'b0;
        run_tab(4);
        commit();
        run_tab(5);

        repeat (4) begin
            pixel_valid = 1'b0;
            repeat (3) write($urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 130),
                             $urandom_range(0, 90), $urandom_range(0, 40), $urandom_range(0, 127),
                             16'($urandom));
            commit();
            repeat (1500) begin
                pixel_valid = ($urandom_range(0, 3) != 0);
                pixel_index = 13'($urandom_range(0, 8191));
                cfg_we = ($urandom_range(0, 15) == 0);
                cfg_sel = 2'($urandom_range(0, 3)); cfg_en = 1'b1;
                cfg_x = 8'($urandom_range(0, 255)); cfg_y = 8'($urandom_range(0, 255));
                cfg_r = 7'($urandom_range(0, 127)); cfg_t = 7'($urandom);
                cfg_color = 16'($urandom);
                tick();
            end
            cfg_we = 1'b0;
            idle(3);
        end

        write(0, 1, 48, 32, 20, 127, 16'h5555);
        commit();
        repeat (10) begin
            pixel_valid = 1'b1;
            pixel_index = 13'($urandom_range(0, 6143));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) begin
            pixel_valid = 1'b1;
            pixel_index = 13'($urandom_range(0, 6143));
            tick();
        end
        idle(3);
        commit();
        run_tab(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
